// File: rtl/panda_pkg.sv
// Shared constants for the panda data memory: MMIO select bit, register offsets and
// CON_STATUS field positions.
package panda_pkg;

    // Address bit that steers an access to MMIO instead of RAM.
    localparam int unsigned MmioSelBit = 31;

    // MMIO register offsets (data_addr_i[7:0]).
    localparam logic [7:0] OffConTx     = 8'h00;
    localparam logic [7:0] OffConStatus = 8'h04;
    localparam logic [7:0] OffCycleLo   = 8'h08;
    localparam logic [7:0] OffCycleHi   = 8'h0C;
    localparam logic [7:0] OffToHost    = 8'h10;

    // CON_STATUS field positions.
    localparam int unsigned ConStatusFullBit  = 0;
    localparam int unsigned ConStatusEmptyBit = 1;
    localparam int unsigned ConStatusCountLsb = 8;

    typedef enum logic {
        RegionRam  = 1'b0,
        RegionMmio = 1'b1
    } region_e;

    // Assemble the CON_STATUS read word; unused bits are zero.
    function automatic logic [31:0] con_status(input logic full, input logic empty,
                                               input logic [7:0] count);
        logic [31:0] s;
        s = '0;
        s[ConStatusFullBit]          = full;
        s[ConStatusEmptyBit]         = empty;
        s[ConStatusCountLsb +: 8]    = count;
        return s;
    endfunction

endpackage

// File: rtl/panda_fifo.sv
// Generic synchronous FIFO with occupancy count. Depth must be a power of two (>= 2) so the
// pointers wrap naturally. A push into a full FIFO is accepted only if a pop happens in the
// same cycle; otherwise it is dropped. No bypass: pushed data is visible the next cycle.
module panda_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head is forced to zero while empty so the output has a defined reset value.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    assign pop_en  = pop_i & ~empty_o;
    assign push_en = push_i & (~full_o | pop_en);

    // Next-state for pointers and occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_en) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_en) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage; when full with a pop, the write lands in the slot being vacated.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/panda_data_mem.sv
// Data memory for the panda core: word RAM with byte-lane writes, plus an MMIO window with a
// console TX FIFO, a test-end TOHOST register and an optional free-running 64-bit cycle counter.
// Define PANDA_DMEM_CYCLE_CNT_EN to include the cycle counter; otherwise CYCLE_LO/HI read 0.
module panda_data_mem
    import panda_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned CON_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    output logic [7:0]  con_data_o,
    output logic        con_valid_o,
    input  logic        con_ready_i,
    output logic        halt_o,
    output logic [31:0] exit_code_o
);

    localparam int unsigned AddrW = $clog2(MEM_WORDS);
    localparam int unsigned CntW  = $clog2(CON_DEPTH) + 1;

    region_e          region;
    logic [AddrW-1:0] ram_idx;
    logic [7:0]       mmio_off;
    logic             ram_we, con_push, con_pop, tohost_we;
    logic             con_full, con_empty;
    logic [CntW-1:0]  con_count;
    logic [7:0]       con_count8;
    logic [31:0]      cycle_lo, cycle_hi;
    logic             halt_q, halt_d;
    logic [31:0]      exit_q, exit_d;
    logic [31:0]      mem_q [MEM_WORDS];

    // High RAM-region bits alias by design; fold the address so every bit is consumed.
    logic unused_addr;
    assign unused_addr = ^data_addr_i;

    assign region   = region_e'(data_addr_i[MmioSelBit]);
    assign ram_idx  = data_addr_i[AddrW+1:2];
    assign mmio_off = data_addr_i[7:0];

    assign ram_we    = (region == RegionRam) & (|data_we_i);
    assign con_push  = (region == RegionMmio) & (mmio_off == OffConTx) & data_we_i[0];
    assign tohost_we = (region == RegionMmio) & (mmio_off == OffToHost) & (|data_we_i);
    assign con_pop   = con_valid_o & con_ready_i;

    // RAM byte-lane writes; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_we_i[b]) begin
                    mem_q[ram_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    panda_fifo #(
        .Width (8),
        .Depth (CON_DEPTH)
    ) u_con_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (con_push),
        .wdata_i (data_wdata_i[7:0]),
        .pop_i   (con_pop),
        .rdata_o (con_data_o),
        .full_o  (con_full),
        .empty_o (con_empty),
        .count_o (con_count)
    );

    assign con_valid_o = ~con_empty;
    assign con_count8  = 8'(con_count);

    // TOHOST captures only the first write; later writes are ignored until reset.
    always_comb begin
        halt_d = halt_q;
        exit_d = exit_q;
        if (tohost_we && !halt_q) begin
            halt_d = 1'b1;
            exit_d = data_wdata_i;
        end
    end

    // Sticky halt flag and exit code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_q <= 1'b0;
            exit_q <= '0;
        end else begin
            halt_q <= halt_d;
            exit_q <= exit_d;
        end
    end

    assign halt_o      = halt_q;
    assign exit_code_o = exit_q;

`ifdef PANDA_DMEM_CYCLE_CNT_EN
    logic [63:0] cycle_q, cycle_d;
    assign cycle_d = cycle_q + 64'd1;

    // Free-running cycle counter, wraps from all-ones to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_lo = cycle_q[31:0];
    assign cycle_hi = cycle_q[63:32];
`else
    assign cycle_lo = '0;
    assign cycle_hi = '0;
`endif

    // Zero-latency read mux; unmapped and write-only MMIO offsets read as zero.
    always_comb begin
        data_rdata_o = '0;
        if (region == RegionRam) begin
            data_rdata_o = mem_q[ram_idx];
        end else begin
            case (mmio_off)
                OffConStatus: data_rdata_o = con_status(con_full, con_empty, con_count8);
                OffCycleLo:   data_rdata_o = cycle_lo;
                OffCycleHi:   data_rdata_o = cycle_hi;
                default:      data_rdata_o = '0;
            endcase
        end
    end

endmodule

// File: doc/panda_data_mem.md
PANDA_DATA_MEM -- requirements
Module: panda_data_mem

Interface
REQ-001 Parameter MEM_WORDS, default 4096, sets RAM depth in 32-bit words (power of 2).
REQ-002 Parameter CON_DEPTH, default 4, sets console FIFO depth in bytes (power of 2, >=2).
REQ-003 Port clk_i  input  1  is the single clock, and all state updates on its rising edge.
REQ-004 Port rst_ni  input  1  is the asynchronous, active-low reset.
REQ-005 Port data_addr_i  input  32  is the byte address from the core MEM stage.
REQ-006 Port data_wdata_i  input  32  is the lane-aligned store data.
REQ-007 Port data_we_i  input  4  gives per-byte write enables, and 0 means a read or idle cycle.
REQ-008 Port data_rdata_o  output  32  is the read data for data_addr_i.
REQ-009 Port con_data_o  output  8  is the console byte at the FIFO head.
REQ-010 Port con_valid_o  output  1  indicates the FIFO is not empty.
REQ-011 Port con_ready_i  input  1  is the console sink ready.
REQ-012 Port halt_o  output  1  is the sticky test-end flag.
REQ-013 Port exit_code_o  output  32  is the value written to TOHOST.

Function
REQ-014 Region select is decided by data_addr_i[31]: 0 selects RAM, 1 selects MMIO, with MMIO offset data_addr_i[7:0].
REQ-015 RAM index is data_addr_i[log2(MEM_WORDS)+1:2], higher RAM-region address bits are ignored (aliasing), and bits [1:0] are ignored.
REQ-016 Reads are combinational with zero latency, and data_rdata_o reflects the current address in the same cycle.
REQ-017 RAM writes update only the enabled byte lanes at the rising edge, and a read of the same word in the write cycle returns the old data.
REQ-018 MMIO map: 0x00 CON_TX (W), 0x04 CON_STATUS (R), 0x08 CYCLE_LO (R), 0x0C CYCLE_HI (R), 0x10 TOHOST (W).
REQ-019 Unmapped MMIO offsets and write-only registers read as 0, and writes to read-only or unmapped offsets are ignored.
REQ-020 CON_STATUS read value: bit0 full, bit1 empty, bits[15:8] current FIFO count, and other bits 0.
REQ-021 A CON_TX write with data_we_i[0]=1 pushes data_wdata_i[7:0], and writes with data_we_i[0]=0 are ignored.
REQ-022 A push is accepted when count<CON_DEPTH, or when the FIFO is full and a pop occurs in the same cycle; otherwise the byte is dropped silently.
REQ-023 A pop occurs when con_valid_o=1 and con_ready_i=1, and con_data_o and con_valid_o are registered-state derived.
REQ-024 FIFO behaviour has no bypass: a push into an empty FIFO raises con_valid_o on the next cycle.
REQ-025 Simultaneous push and pop on a non-empty FIFO leaves the count unchanged and keeps the byte order.
REQ-026 FIFO pointers wrap modulo CON_DEPTH.
REQ-027 The first TOHOST write with any enable set drives halt_o=1 and exit_code_o=data_wdata_i from the next cycle; later TOHOST writes are ignored.
REQ-028 halt_o stays 1 until reset, and RAM and console continue operating after halt.
REQ-029 The 64-bit cycle counter increments every cycle after reset release and wraps from all-ones to 0.
REQ-030 CYCLE_LO and CYCLE_HI return the live counter halves, with no snapshot.

Reset
REQ-031 Asserting rst_ni low asynchronously clears the FIFO (count 0, pointers 0), the counter, halt_o, and exit_code_o.
REQ-032 The output reset values are con_valid_o=0, con_data_o=0, halt_o=0, and exit_code_o=0; data_rdata_o stays combinational.
REQ-033 RAM contents are not reset, and a mid-operation reset discards all FIFO bytes pending in the FIFO.

Configuration
REQ-034 With PANDA_DMEM_CYCLE_CNT_EN defined, the counter of REQ-029/030 is present.
REQ-035 Without PANDA_DMEM_CYCLE_CNT_EN, the counter logic is absent, and CYCLE_LO and CYCLE_HI read as 0.

Structure
REQ-036 panda_pkg holds the MMIO base bit, the register offset constants, and the CON_STATUS bit positions.
REQ-037 The console FIFO is the sub-module panda_fifo (generic synchronous FIFO: push, pop, full, empty, count).

Verification
REQ-038 Store 0xDEADBEEF to 0x100 with we=0xF, then read 0x100 -> 0xDEADBEEF; store 0x000000AA with we=0x1 -> 0xDEADBEAA.
REQ-039 Read 0x100 in the same cycle as a write of 0x11223344 -> old value; the next cycle -> 0x11223344.
REQ-040 Push 'A','B','C','D','E' with con_ready_i=0 and CON_DEPTH=4 -> status full=1 and count=4, 'E' dropped; raise ready -> A,B,C,D out in 4 cycles, then empty=1.
REQ-041 Full FIFO with ready=1 and push 'Z' in the same cycle -> push accepted, count stays 4, and 'Z' is emitted last.
REQ-042 Write 0x1 then 0x2 to TOHOST -> halt_o=1 and exit_code_o=0x1 the next cycle, and it remains 0x1.
REQ-043 With the macro defined, CYCLE_LO read 10 cycles after reset release -> 10; with the macro undefined -> 0.
